// File: rtl/pipeline_stall_ctrl.sv
// Pipeline latch load/squash controller: merges split imem/dmem responses,
// inserts load-use bubbles, flushes on MEM-resolved taken branches, counts events.
module pipeline_stall_ctrl #(
   parameter int CNT_WIDTH      = 16,
   parameter int REG_ADDR_WIDTH = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      imem_resp,
   input  logic                      dmem_req,
   input  logic                      dmem_resp,
   input  logic                      br_taken,
   input  logic                      ex_is_load,
   input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
   input  logic [REG_ADDR_WIDTH-1:0] id_sr1,
   input  logic [REG_ADDR_WIDTH-1:0] id_sr2,
   input  logic                      id_uses_sr1,
   input  logic                      id_uses_sr2,
   output logic                      imem_read,
   output logic                      dmem_read_en,
   output logic                      if_buf_load,
   output logic                      if_buf_sel,
   output logic                      load_pc,
   output logic                      load_if_id,
   output logic                      load_id_ex,
   output logic                      load_ex_mem,
   output logic                      load_mem_wb,
   output logic                      squash_if_id,
   output logic                      squash_id_ex,
   output logic                      squash_ex_mem,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      bubble_count,
   output logic [CNT_WIDTH-1:0]      flush_count,
   output logic [1:0]                state_dbg
);

   // State bits are {imem_got, dmem_got}; 2'b11 cannot occur.
   typedef enum logic [1:0] {
      RUN    = 2'b00,
      WAIT_I = 2'b01,
      WAIT_D = 2'b10
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;
   logic [CNT_WIDTH-1:0]  bubble_q, bubble_d;
   logic [CNT_WIDTH-1:0]  flush_q, flush_d;
   logic                  imem_got, dmem_got;
   logic                  imem_done, dmem_done, advance, hazard;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   assign imem_got  = state_q[1];
   assign dmem_got  = state_q[0];
   assign imem_done = imem_resp | imem_got;
   assign dmem_done = ~dmem_req | dmem_resp | dmem_got;
   assign advance   = imem_done & dmem_done;
   assign hazard    = ex_is_load & ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                                    (id_uses_sr2 & (id_sr2 == ex_dest)));

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
   end

   always_comb begin
      state_d       = state_q;
      stall_d       = stall_q;
      bubble_d      = bubble_q;
      flush_d       = flush_q;
      imem_read     = 1'b0;
      dmem_read_en  = 1'b0;
      if_buf_load   = 1'b0;
      if_buf_sel    = 1'b0;
      load_pc       = 1'b0;
      load_if_id    = 1'b0;
      load_id_ex    = 1'b0;
      load_ex_mem   = 1'b0;
      load_mem_wb   = 1'b0;
      squash_if_id  = 1'b0;
      squash_id_ex  = 1'b0;
      squash_ex_mem = 1'b0;
      if (reset) begin
         // Keep the pipe clocking NOPs in while the PC holds.
         state_d       = RUN;
         stall_d       = '0;
         bubble_d      = '0;
         flush_d       = '0;
         load_if_id    = 1'b1;
         load_id_ex    = 1'b1;
         load_ex_mem   = 1'b1;
         load_mem_wb   = 1'b1;
         squash_if_id  = 1'b1;
         squash_id_ex  = 1'b1;
         squash_ex_mem = 1'b1;
      end else begin
         imem_read    = ~imem_got;
         dmem_read_en = dmem_req & ~dmem_got;
         if_buf_load  = imem_resp & ~advance;
         if_buf_sel   = imem_got;
         state_d      = state_t'({~advance & (imem_got | imem_resp),
                                  ~advance & (dmem_got | (dmem_req & dmem_resp))});
         if (!advance) begin
            stall_d = sat_inc(stall_q);
         end else if (br_taken) begin
            load_pc       = 1'b1;
            load_if_id    = 1'b1;
            load_id_ex    = 1'b1;
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            squash_if_id  = 1'b1;
            squash_id_ex  = 1'b1;
            squash_ex_mem = 1'b1;
            flush_d       = sat_inc(flush_q);
         end else if (hazard) begin
            // Hold PC and IF/ID; the load moves on and a bubble enters EX.
            load_id_ex    = 1'b1;
            squash_id_ex  = 1'b1;
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            bubble_d      = sat_inc(bubble_q);
         end else begin
            load_pc       = 1'b1;
            load_if_id    = 1'b1;
            load_id_ex    = 1'b1;
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
         end
      end
   end

   assign stall_count  = stall_q;
   assign bubble_count = bubble_q;
   assign flush_count  = flush_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: each driven cycle pushes its expected
// output vector; a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

   localparam int W = 62;
   // ctrl = {imem_read, dmem_read_en, if_buf_load, if_buf_sel,
   //         load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
   //         squash_if_id, squash_id_ex, squash_ex_mem}
   localparam logic [11:0] C_RST  = 12'b0000_01111_111;
   localparam logic [11:0] C_NORM = 12'b1000_11111_000;
   localparam logic [11:0] C_FRZ  = 12'b1000_00000_000;
   localparam logic [11:0] C_BUB  = 12'b1000_00111_010;

   logic clk = 1'b0;
   logic reset;
   logic imem_resp, dmem_req, dmem_resp, br_taken, ex_is_load;
   logic [2:0] ex_dest, id_sr1, id_sr2;
   logic id_uses_sr1, id_uses_sr2;
   logic imem_read, dmem_read_en, if_buf_load, if_buf_sel;
   logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic squash_if_id, squash_id_ex, squash_ex_mem;
   logic [15:0] stall_count, bubble_count, flush_count;
   logic [1:0] state_dbg;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.CNT_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
      .clk(clk), .reset(reset),
      .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .br_taken(br_taken), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
      .id_sr1(id_sr1), .id_sr2(id_sr2),
      .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
      .imem_read(imem_read), .dmem_read_en(dmem_read_en),
      .if_buf_load(if_buf_load), .if_buf_sel(if_buf_sel),
      .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
      .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
      .squash_if_id(squash_if_id), .squash_id_ex(squash_id_ex),
      .squash_ex_mem(squash_ex_mem),
      .stall_count(stall_count), .bubble_count(bubble_count),
      .flush_count(flush_count), .state_dbg(state_dbg)
   );

   task automatic step(input logic rst, input logic i_resp, input logic d_req,
                       input logic d_resp, input logic br, input logic ld,
                       input logic [2:0] dest, input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic [11:0] e_ctrl,
                       input logic [15:0] e_st, input logic [15:0] e_bu,
                       input logic [15:0] e_fl, input logic [1:0] e_state);
      @(posedge clk);
      #1;
      reset = rst; imem_resp = i_resp; dmem_req = d_req; dmem_resp = d_resp;
      br_taken = br; ex_is_load = ld; ex_dest = dest; id_sr1 = s1; id_sr2 = s2;
      id_uses_sr1 = u1; id_uses_sr2 = u2;
      exp_q.push_back({e_ctrl, e_st, e_bu, e_fl, e_state});
   endtask

   always @(negedge clk) begin
      logic [W-1:0] exp_v, act_v;
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         act_v = {imem_read, dmem_read_en, if_buf_load, if_buf_sel,
                  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  squash_if_id, squash_id_ex, squash_ex_mem,
                  stall_count, bubble_count, flush_count, state_dbg};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL out_vec check %0d @%0t: ctrl got %b want %b, stall got %h want %h, bubble got %h want %h, flush got %h want %h, state got %b want %b",
                     checks, $time, act_v[61:50], exp_v[61:50], act_v[49:34], exp_v[49:34],
                     act_v[33:18], exp_v[33:18], act_v[17:2], exp_v[17:2], act_v[1:0], exp_v[1:0]);
         end
      end
   end

   initial begin
      int v;
      reset = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
      br_taken = 1'b0; ex_is_load = 1'b0; ex_dest = '0; id_sr1 = '0; id_sr2 = '0;
      id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0;
      repeat (2) @(posedge clk);

      // reset held, then release into a normal fetch
      step(1,1,0,0,0,0,0,0,0,0,0, C_RST, 16'd0,16'd0,16'd0, 2'b00);
      step(1,1,0,0,0,0,0,0,0,0,0, C_RST, 16'd0,16'd0,16'd0, 2'b00);
      step(0,1,0,0,0,0,0,0,0,0,0, C_NORM,16'd0,16'd0,16'd0, 2'b00);
      // split responses: imem first, dmem two cycles later
      step(0,1,1,0,0,0,0,0,0,0,0, 12'b1110_00000_000, 16'd0,16'd0,16'd0, 2'b00);
      step(0,0,1,0,0,0,0,0,0,0,0, 12'b0101_00000_000, 16'd1,16'd0,16'd0, 2'b10);
      step(0,0,1,1,0,0,0,0,0,0,0, 12'b0101_11111_000, 16'd2,16'd0,16'd0, 2'b10);
      // load-use hazards and near misses
      step(0,1,0,0,0,1,3'd3,3'd0,3'd3,0,1, C_BUB, 16'd2,16'd0,16'd0, 2'b00);
      step(0,1,0,0,0,1,3'd3,3'd3,3'd3,0,0, C_NORM,16'd2,16'd1,16'd0, 2'b00);
      step(0,1,0,0,0,0,3'd3,3'd3,3'd3,1,1, C_NORM,16'd2,16'd1,16'd0, 2'b00);
      step(0,1,0,0,0,1,3'd5,3'd5,3'd3,1,1, C_BUB, 16'd2,16'd1,16'd0, 2'b00);
      step(0,1,0,0,0,1,3'd4,3'd5,3'd3,1,1, C_NORM,16'd2,16'd2,16'd0, 2'b00);
      // branch beats hazard; freeze beats branch
      step(0,1,1,1,1,1,3'd3,3'd0,3'd3,0,1, 12'b1100_11111_111, 16'd2,16'd2,16'd0, 2'b00);
      step(0,1,0,0,0,0,0,0,0,0,0, C_NORM,16'd2,16'd2,16'd1, 2'b00);
      step(0,0,0,0,1,0,0,0,0,0,0, C_FRZ, 16'd2,16'd2,16'd1, 2'b00);
      step(0,1,0,0,0,0,0,0,0,0,0, C_NORM,16'd3,16'd2,16'd1, 2'b00);
      // data first, then reset while waiting on imem
      step(0,0,1,1,0,0,0,0,0,0,0, 12'b1100_00000_000, 16'd3,16'd2,16'd1, 2'b00);
      step(0,0,1,0,0,0,0,0,0,0,0, C_FRZ, 16'd4,16'd2,16'd1, 2'b01);
      step(1,0,1,0,0,0,0,0,0,0,0, C_RST, 16'd5,16'd2,16'd1, 2'b01);
      step(0,0,1,0,0,0,0,0,0,0,0, 12'b1100_00000_000, 16'd0,16'd0,16'd0, 2'b00);
      // long imem stall: stall counter saturates
      for (int k = 0; k < 65540; k++) begin
         v = 1 + k;
         step(0,0,0,0,0,0,0,0,0,0,0, C_FRZ, (v > 65535) ? 16'hFFFF : 16'(v),
              16'd0,16'd0, 2'b00);
      end
      step(0,1,0,0,0,0,0,0,0,0,0, C_NORM,16'hFFFF,16'd0,16'd0, 2'b00);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
